hella_cache_slave_mem: RTL and testbench

//  Responder memory model on the far side of a hella-cache request/response port.

---
 rtl/hella_cache_pkg.sv | 40 ++++
 rtl/hella_cache_slave_mem_if.sv | 35 +++
 rtl/hella_cache_slave_mem_array.sv | 33 +++
 rtl/hella_cache_slave_mem.sv | 171 +++++++++++++++++
 tb/tb_hella_cache_slave_mem.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hella_cache_pkg.sv
// Shared command codes, access-size encoding and read-data extension helper
// for the hella-cache slave memory model.
package hella_cache_pkg;

    localparam logic [4:0] M_XRD = 5'd0;
    localparam logic [4:0] M_XWR = 5'd1;

    typedef enum logic [1:0] {
        MT_B = 2'd0,
        MT_H = 2'd1,
        MT_W = 2'd2,
        MT_D = 2'd3
    } mt_size_e;

    // Shift the word down to the byte offset, keep the access size, then sign-
    // or zero-extend; sizes wider than the data path collapse to the full word.
    function automatic logic [63:0] extend_rdata(input logic [63:0] data,
                                                 input logic [2:0]  offset,
                                                 input logic [2:0]  typ,
                                                 input int unsigned data_bytes);
        logic [63:0] sh;
        logic [63:0] res;
        mt_size_e    sz;
        logic        sext;
        sh   = data >> {offset, 3'b000};
        sz   = mt_size_e'(typ[1:0]);
        sext = ~typ[2];
        if ((data_bytes == 4) && (sz == MT_D)) begin
            sz = MT_W;
        end
        case (sz)
            MT_B:    res = {{56{sext & sh[7]}}, sh[7:0]};
            MT_H:    res = {{48{sext & sh[15]}}, sh[15:0]};
            MT_W:    res = {{32{sext & sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hella_cache_slave_mem_if.sv
// Request/response bundle between a hella-cache master and the slave memory.
interface hella_cache_slave_mem_if #(
    parameter int unsigned NUM_ADDR_BITS = 32,
    parameter int unsigned NUM_DATA_BITS = 32,
    parameter int unsigned NUM_TAG_BITS  = 7
) ();

    logic [NUM_ADDR_BITS-1:0]   req_addr;
    logic                       req_ready;
    logic                       req_valid;
    logic [NUM_TAG_BITS-1:0]    req_tag;
    logic [4:0]                 req_cmd;
    logic [2:0]                 req_typ;
    logic [NUM_DATA_BITS-1:0]   req_data;
    logic [NUM_DATA_BITS/8-1:0] req_data_mask;
    logic                       req_kill;
    logic                       rsp_valid;
    logic                       rsp_nack;
    logic [NUM_TAG_BITS-1:0]    rsp_tag;
    logic [2:0]                 rsp_typ;
    logic [NUM_DATA_BITS-1:0]   rsp_data;

    modport master (
        output req_addr, req_valid, req_tag, req_cmd, req_typ, req_data, req_data_mask,
               req_kill,
        input  req_ready, rsp_valid, rsp_nack, rsp_tag, rsp_typ, rsp_data
    );

    modport slave (
        input  req_addr, req_valid, req_tag, req_cmd, req_typ, req_data, req_data_mask,
               req_kill,
        output req_ready, rsp_valid, rsp_nack, rsp_tag, rsp_typ, rsp_data
    );

endinterface

// File: rtl/hella_cache_slave_mem_array.sv
// Word array with one byte-enabled write port and one asynchronous read port.
// Contents are intentionally not reset.
module hella_cache_slave_mem_array #(
    parameter int unsigned NUM_DATA_BITS = 32,
    parameter int unsigned MEM_ADDR_BITS = 10
) (
    input  logic                       i_clock,
    input  logic                       i_we,
    input  logic [MEM_ADDR_BITS-1:0]   i_waddr,
    input  logic [NUM_DATA_BITS-1:0]   i_wdata,
    input  logic [NUM_DATA_BITS/8-1:0] i_wbe,
    input  logic [MEM_ADDR_BITS-1:0]   i_raddr,
    output logic [NUM_DATA_BITS-1:0]   o_rdata
);

    localparam int unsigned Depth    = 1 << MEM_ADDR_BITS;
    localparam int unsigned NumBytes = NUM_DATA_BITS / 8;

    logic [NUM_DATA_BITS-1:0] r_mem [Depth];

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            for (int b = 0; b < int'(NumBytes); b++) begin
                if (i_wbe[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hella_cache_slave_mem.sv
// Hella-cache responder memory: two-stage request pipeline, tagged responses two
// cycles after accept. Optional periodic nack injection under HELLA_CACHE_SLAVE_NACK_EN.
module hella_cache_slave_mem
    import hella_cache_pkg::*;
#(
    parameter int unsigned NUM_ADDR_BITS = 32,
    parameter int unsigned NUM_DATA_BITS = 32,
    parameter int unsigned NUM_TAG_BITS  = 7,
    parameter int unsigned MEM_ADDR_BITS = 10,
    parameter int unsigned READY_GAP     = 0,
    parameter int unsigned NACK_PERIOD   = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    hella_cache_slave_mem_if.slave  bus
);

    localparam int unsigned NumBytes = NUM_DATA_BITS / 8;
    localparam int unsigned OffBits  = $clog2(NumBytes);
    localparam int unsigned GapBits  = (READY_GAP > 0) ? $clog2(READY_GAP + 1) : 1;

    logic                     r_ready;
    logic [GapBits-1:0]       r_gap_cnt;
    logic [GapBits-1:0]       w_gap_nxt;

    logic                     r_s1_valid;
    logic [MEM_ADDR_BITS-1:0] r_s1_word;
    logic [OffBits-1:0]       r_s1_off;
    logic                     r_s1_wr;
    logic [NUM_TAG_BITS-1:0]  r_s1_tag;
    logic [2:0]               r_s1_typ;
    logic [NUM_DATA_BITS-1:0] r_s1_data;
    logic [NumBytes-1:0]      r_s1_mask;

    logic                     r_s2_valid;
    logic [MEM_ADDR_BITS-1:0] r_s2_word;
    logic                     r_s2_wr;
    logic [NUM_TAG_BITS-1:0]  r_s2_tag;
    logic [2:0]               r_s2_typ;
    logic [NUM_DATA_BITS-1:0] r_s2_data;
    logic [NumBytes-1:0]      r_s2_mask;
    logic [NUM_DATA_BITS-1:0] r_s2_rdata;

    logic                     w_accept;
    logic                     w_s1_adv;
    logic                     w_nack;
    logic                     w_rsp_valid;
    logic                     w_commit_wr;
    logic [NUM_DATA_BITS-1:0] w_rd_word;
    logic [NUM_DATA_BITS-1:0] w_rd_merged;
    logic [63:0]              w_ext;

    assign w_accept    = bus.req_valid & r_ready;
    assign w_s1_adv    = r_s1_valid & ~bus.req_kill;
    assign w_rsp_valid = r_s2_valid & ~w_nack;
    assign w_commit_wr = w_rsp_valid & r_s2_wr;

    always_comb begin
        w_gap_nxt = r_gap_cnt;
        if (w_accept) begin
            w_gap_nxt = GapBits'(READY_GAP);
        end else if (r_gap_cnt != '0) begin
            w_gap_nxt = r_gap_cnt - GapBits'(1);
        end
    end

    // The array is read while the entry sits in S1; a write committing from S2 on
    // the same edge is merged in so the read sees write-first ordering.
    always_comb begin
        w_rd_merged = w_rd_word;
        for (int b = 0; b < int'(NumBytes); b++) begin
            if (w_commit_wr && (r_s2_word == r_s1_word) && r_s2_mask[b]) begin
                w_rd_merged[8*b +: 8] = r_s2_data[8*b +: 8];
            end
        end
    end

    assign w_ext = extend_rdata(64'(w_rd_merged), 3'(r_s1_off), r_s1_typ, NumBytes);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ready    <= 1'b0;
            r_gap_cnt  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_word  <= '0;
            r_s1_off   <= '0;
            r_s1_wr    <= 1'b0;
            r_s1_tag   <= '0;
            r_s1_typ   <= '0;
            r_s1_data  <= '0;
            r_s1_mask  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_word  <= '0;
            r_s2_wr    <= 1'b0;
            r_s2_tag   <= '0;
            r_s2_typ   <= '0;
            r_s2_data  <= '0;
            r_s2_mask  <= '0;
            r_s2_rdata <= '0;
        end else begin
            r_gap_cnt  <= w_gap_nxt;
            r_ready    <= (w_gap_nxt == '0);
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_word <= bus.req_addr[MEM_ADDR_BITS+OffBits-1:OffBits];
                r_s1_off  <= bus.req_addr[OffBits-1:0];
                r_s1_wr   <= (bus.req_cmd == M_XWR);
                r_s1_tag  <= bus.req_tag;
                r_s1_typ  <= bus.req_typ;
                r_s1_data <= bus.req_data;
                r_s1_mask <= bus.req_data_mask;
            end
            r_s2_valid <= w_s1_adv;
            if (w_s1_adv) begin
                r_s2_word  <= r_s1_word;
                r_s2_wr    <= r_s1_wr;
                r_s2_tag   <= r_s1_tag;
                r_s2_typ   <= r_s1_typ;
                r_s2_data  <= r_s1_data;
                r_s2_mask  <= r_s1_mask;
                r_s2_rdata <= r_s1_wr ? '0 : w_ext[NUM_DATA_BITS-1:0];
            end
        end
    end

`ifdef HELLA_CACHE_SLAVE_NACK_EN
    localparam int unsigned NackBits = $clog2(NACK_PERIOD);

    logic [NackBits-1:0] r_nack_cnt;

    assign w_nack = r_s2_valid & (r_nack_cnt == NackBits'(NACK_PERIOD - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_nack_cnt <= '0;
        end else if (r_s2_valid) begin
            r_nack_cnt <= w_nack ? '0 : r_nack_cnt + NackBits'(1);
        end
    end
`else
    logic w_unused_nack_period;

    assign w_nack               = 1'b0;
    assign w_unused_nack_period = (NACK_PERIOD >= 2);
`endif

    hella_cache_slave_mem_array #(
        .NUM_DATA_BITS (NUM_DATA_BITS),
        .MEM_ADDR_BITS (MEM_ADDR_BITS)
    ) u_array (
        .i_clock (clock),
        .i_we    (w_commit_wr),
        .i_waddr (r_s2_word),
        .i_wdata (r_s2_data),
        .i_wbe   (r_s2_mask),
        .i_raddr (r_s1_word),
        .o_rdata (w_rd_word)
    );

    // Address bits above the array aliase; only the low extension bits are kept.
    logic w_unused_bits;
    assign w_unused_bits = ^{bus.req_addr[NUM_ADDR_BITS-1:MEM_ADDR_BITS+OffBits], w_ext};

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_nack  = w_nack;
    assign bus.rsp_tag   = r_s2_tag;
    assign bus.rsp_typ   = r_s2_typ;
    assign bus.rsp_data  = w_rsp_valid ? r_s2_rdata : '0;

endmodule

// File: tb/tb_hella_cache_slave_mem.sv
// Self-checking bench for hella_cache_slave_mem: byte-array memory model with an
// in-order expected-response queue, directed cases plus randomized traffic.
module tb_hella_cache_slave_mem;

    localparam int unsigned NACK_P = 4;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    hella_cache_slave_mem_if #(
        .NUM_ADDR_BITS (32),
        .NUM_DATA_BITS (32),
        .NUM_TAG_BITS  (7)
    ) bus ();

    hella_cache_slave_mem #(
        .NUM_ADDR_BITS (32),
        .NUM_DATA_BITS (32),
        .NUM_TAG_BITS  (7),
        .MEM_ADDR_BITS (10),
        .READY_GAP     (0),
        .NACK_PERIOD   (NACK_P)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
        bit          is_wr;
        logic [2:0]  typ;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [6:0]  tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem [4096];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          n_seen = 0;
    int          status [128];
    logic [31:0] last_data [128];
    int          rsp_cyc [128];
    bit          s1_pending = 0;
    bit          kill_next = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [2:0] typ);
        int          n;
        int          off;
        int          base;
        logic [31:0] v;
        n = 1 << typ[1:0];
        if (n > 4) n = 4;
        off  = int'(addr & 32'h3);
        base = int'(addr & 32'hFFC);
        v = 0;
        for (int i = 0; i < n; i++) begin
            if (off + i < 4) v = v | (32'(mem[base + off + i]) << (8 * i));
        end
        if (!typ[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin : cmp_p
        exp_t        e;
        bit          nk;
        logic [31:0] ed;
        if (!reset_n) begin
            exp_q.delete();
            n_seen = 0;
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
`ifdef HELLA_CACHE_SLAVE_NACK_EN
            nk = (n_seen % NACK_P) == (NACK_P - 1);
`else
            nk = 1'b0;
`endif
            n_seen++;
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(!nk));
            chk("rsp_nack", 32'(bus.rsp_nack), 32'(nk));
            chk("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
            chk("rsp_typ", 32'(bus.rsp_typ), 32'(e.typ));
            if (!nk) begin
                ed = e.is_wr ? 32'h0 : model_read(e.addr, e.typ);
                chk("rsp_data", bus.rsp_data, ed);
                if (e.is_wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (e.mask[b]) mem[int'(e.addr & 32'hFFC) + b] = e.data[8*b +: 8];
                    end
                end
            end
            status[e.tag]    = nk ? 2 : 1;
            last_data[e.tag] = bus.rsp_data;
            rsp_cyc[e.tag]   = cyc;
        end else begin
            chk("idle_valid", 32'(bus.rsp_valid), 32'h0);
            chk("idle_nack", 32'(bus.rsp_nack), 32'h0);
        end
    end

    task automatic slot(input bit have, input logic [31:0] addr, input logic [4:0] cmd,
                        input logic [2:0] typ, input logic [31:0] data, input logic [3:0] mask,
                        input logic [6:0] tag, input bit kill, output bit acc);
        exp_t e;
        @(negedge clock);
        bus.req_kill      = s1_pending ? kill_next : ($urandom_range(0, 3) == 0);
        s1_pending        = 0;
        kill_next         = 0;
        bus.req_valid     = have;
        bus.req_addr      = addr;
        bus.req_cmd       = cmd;
        bus.req_typ       = typ;
        bus.req_data      = data;
        bus.req_data_mask = mask;
        bus.req_tag       = tag;
        acc = have && bus.req_ready && reset_n;
        if (acc) begin
            s1_pending = 1;
            kill_next  = kill;
            if (!kill) begin
                e.due = cyc + 2; e.addr = addr; e.is_wr = (cmd == 5'd1); e.typ = typ;
                e.data = data; e.mask = mask; e.tag = tag;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle_slot();
        bit acc;
        slot(0, 32'h0, 5'd0, 3'd0, 32'h0, 4'h0, 7'd0, 0, acc);
    endtask

    task automatic send(input logic [31:0] addr, input logic [4:0] cmd, input logic [2:0] typ,
                        input logic [31:0] data, input logic [3:0] mask, input logic [6:0] tag,
                        input bit kill);
        bit acc;
        int tries = 0;
        do begin
            slot(1, addr, cmd, typ, data, mask, tag, kill, acc);
            tries++;
        end while (!acc && tries < 20);
        if (!acc) chk("accept_timeout", 32'h0, 32'h1);
    endtask

    // Issue, wait for the response and replay on nack, like a master would.
    task automatic txn(input logic [31:0] addr, input logic [4:0] cmd, input logic [2:0] typ,
                       input logic [31:0] data, input logic [3:0] mask, input logic [6:0] tag);
        int tries = 0;
        int w;
        do begin
            status[tag] = 0;
            send(addr, cmd, typ, data, mask, tag, 0);
            w = 0;
            while (status[tag] == 0 && w < 20) begin
                idle_slot();
                w++;
            end
            if (status[tag] == 0) chk("rsp_timeout", 32'h0, 32'h1);
            tries++;
        end while (status[tag] == 2 && tries < 8);
    endtask

    initial begin : main_p
        bit          acc;
        int          w;
        logic [31:0] a;
        logic [4:0]  c;
        reset_n           = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_kill      = 1'b0;
        bus.req_addr      = '0;
        bus.req_cmd       = '0;
        bus.req_typ       = '0;
        bus.req_data      = '0;
        bus.req_data_mask = '0;
        bus.req_tag       = '0;
        for (int i = 0; i < 128; i++) status[i] = 0;
        repeat (3) @(negedge clock);
        chk("reset_ready", 32'(bus.req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("reset_rsp_nack", 32'(bus.rsp_nack), 32'h0);
        chk("reset_rsp_data", bus.rsp_data, 32'h0);
        chk("reset_rsp_tag", 32'(bus.rsp_tag), 32'h0);
        #2 reset_n = 1'b1;
        #1 chk("ready_at_release", 32'(bus.req_ready), 32'h0);
        @(negedge clock);
        chk("ready_after_release", 32'(bus.req_ready), 32'h1);

        for (int i = 0; i < 16; i++) begin
            txn(32'(4 * i), 5'd1, 3'd2, {16'hC0DE, 16'(4 * i)}, 4'hF, 7'(100 + i));
        end

        // Word write and read back
        txn(32'h10, 5'd1, 3'd2, 32'hA5A5_1234, 4'hF, 7'd3);
        chk("t1_wr_status", 32'(status[3]), 32'h1);
        chk("t1_wr_data", last_data[3], 32'h0);
        txn(32'h10, 5'd0, 3'd2, 32'h0, 4'h0, 7'd4);
        chk("t1_rd_data", last_data[4], 32'hA5A5_1234);
        chk("model_pin_w", model_read(32'h10, 3'd2), 32'hA5A5_1234);
        chk("model_pin_b", model_read(32'h11, 3'd0), 32'h0000_0012);

        // Byte/half sign and zero extension, oversize clamp
        txn(32'h11, 5'd0, 3'd0, 32'h0, 4'h0, 7'd5);
        chk("t2_rd_b11", last_data[5], 32'h0000_0012);
        txn(32'h13, 5'd1, 3'd0, 32'h8000_0000, 4'b1000, 7'd6);
        txn(32'h13, 5'd0, 3'd0, 32'h0, 4'h0, 7'd7);
        chk("t2_rd_b13_signed", last_data[7], 32'hFFFF_FF80);
        txn(32'h13, 5'd0, 3'd4, 32'h0, 4'h0, 7'd8);
        chk("t2_rd_b13_unsigned", last_data[8], 32'h0000_0080);
        chk("model_pin_bs", model_read(32'h13, 3'd0), 32'hFFFF_FF80);
        txn(32'h12, 5'd0, 3'd1, 32'h0, 4'h0, 7'd11);
        chk("t2_rd_h12_signed", last_data[11], 32'hFFFF_80A5);
        txn(32'h10, 5'd7, 3'd3, 32'h0, 4'h0, 7'd12);
        chk("t2_rd_d_clamp_othercmd", last_data[12], 32'h80A5_1234);

        // Killed write leaves no trace
        status[9] = 0;
        send(32'h10, 5'd1, 3'd2, 32'hDEAD_BEEF, 4'hF, 7'd9, 1);
        txn(32'h10, 5'd0, 3'd2, 32'h0, 4'h0, 7'd10);
        chk("t3_kill_no_rsp", 32'(status[9]), 32'h0);
        chk("t3_old_value", last_data[10], 32'h80A5_1234);

        // Back-to-back traffic, including a read right behind its partial write
        for (int i = 20; i < 28; i++) status[i] = 0;
        send(32'h24, 5'd1, 3'd2, 32'h1111_0001, 4'hF, 7'd20, 0);
        send(32'h28, 5'd1, 3'd2, 32'h1111_0002, 4'hF, 7'd21, 0);
        send(32'h2C, 5'd1, 3'd2, 32'h1111_0003, 4'hF, 7'd22, 0);
        send(32'h24, 5'd0, 3'd2, 32'h0, 4'h0, 7'd23, 0);
        send(32'h28, 5'd0, 3'd2, 32'h0, 4'h0, 7'd24, 0);
        send(32'h2C, 5'd0, 3'd2, 32'h0, 4'h0, 7'd25, 0);
        send(32'h30, 5'd1, 3'd2, 32'hAABB_CCDD, 4'b0101, 7'd26, 0);
        send(32'h30, 5'd0, 3'd2, 32'h0, 4'h0, 7'd27, 0);
        w = 0;
        while (status[27] == 0 && w < 20) begin
            idle_slot();
            w++;
        end
        for (int k = 1; k < 8; k++) begin
            chk("t5_consecutive", 32'(rsp_cyc[20 + k]), 32'(rsp_cyc[20] + k));
        end
        if (status[23] == 1) chk("t5_rd24", last_data[23], 32'h1111_0001);
        if (status[24] == 1) chk("t5_rd28", last_data[24], 32'h1111_0002);
        if (status[25] == 1) chk("t5_rd2c", last_data[25], 32'h1111_0003);
        if (status[27] == 1) chk("t5_bypass", last_data[27], 32'hC0BB_00DD);

        // Reset while a read sits in S2 and a write sits in S1
        status[30] = 0;
        slot(1, 32'h10, 5'd0, 3'd2, 32'h0, 4'h0, 7'd30, 0, acc);
        chk("t6_rd_acc", 32'(acc), 32'h1);
        slot(1, 32'h20, 5'd1, 3'd2, 32'hFFFF_FFFF, 4'hF, 7'd31, 0, acc);
        chk("t6_wr_acc", 32'(acc), 32'h1);
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_kill  = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("t6_valid_drop", 32'(bus.rsp_valid), 32'h0);
        chk("t6_nack_drop", 32'(bus.rsp_nack), 32'h0);
        chk("t6_ready_drop", 32'(bus.req_ready), 32'h0);
        s1_pending = 0;
        kill_next  = 0;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        #1 chk("t6_ready_at_release", 32'(bus.req_ready), 32'h0);
        @(negedge clock);
        chk("t6_ready_after_release", 32'(bus.req_ready), 32'h1);

`ifdef HELLA_CACHE_SLAVE_NACK_EN
        for (int i = 40; i < 44; i++) status[i] = 0;
        for (int i = 40; i < 44; i++) send(32'h10, 5'd0, 3'd2, 32'h0, 4'h0, 7'(i), 0);
        w = 0;
        while (status[43] == 0 && w < 20) begin
            idle_slot();
            w++;
        end
        chk("t4_tag0", 32'(status[40]), 32'h1);
        chk("t4_tag1", 32'(status[41]), 32'h1);
        chk("t4_tag2", 32'(status[42]), 32'h1);
        chk("t4_tag3_nack", 32'(status[43]), 32'h2);
        txn(32'h10, 5'd0, 3'd2, 32'h0, 4'h0, 7'd43);
        chk("t4_replay", 32'(status[43]), 32'h1);
`endif

        txn(32'h10, 5'd0, 3'd2, 32'h0, 4'h0, 7'd32);
        chk("t6_keep_old", last_data[32], 32'h80A5_1234);
        txn(32'h20, 5'd0, 3'd2, 32'h0, 4'h0, 7'd33);
        chk("t6_s1_discarded", last_data[33], 32'hC0DE_0020);

        // Random traffic over 16 words with aliasing upper address bits
        for (int n = 0; n < 400; n++) begin
            a = $urandom & 32'hFFFF_F03F;
            case ($urandom_range(0, 3))
                0:       c = 5'd0;
                1:       c = 5'd1;
                2:       c = 5'($urandom_range(2, 31));
                default: c = 5'd1;
            endcase
            slot($urandom_range(0, 4) != 0, a, c, 3'($urandom), $urandom, 4'($urandom),
                 7'($urandom), $urandom_range(0, 7) == 0, acc);
        end
        repeat (10) idle_slot();
        chk("drain", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog_p
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
